// File: rtl/clr_en_dff_pipe_pkg.sv
// Shared definitions for the clear/enable DFF pipeline.
// Holds the occupancy-count width helper used by the top level and the bus interface.
package clr_en_dff_pipe_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 2;

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/clr_en_dff_pipe_if.sv
// Valid/ready bus of the clear/enable DFF pipeline, including flush and occupancy.
// The slave modport is the pipeline side; the master modport is its environment.
interface clr_en_dff_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
);
  import clr_en_dff_pipe_pkg::*;

  logic                          iClr;
  logic                          iVld;
  logic                          oRdy;
  logic [WIDTH-1:0]              iDat;
  logic                          oVld;
  logic                          iRdy;
  logic [WIDTH-1:0]              oDat;
  logic [cnt_width(DEPTH)-1:0]   oCnt;

  modport master (
    output iClr, iVld, iDat, iRdy,
    input  oRdy, oVld, oDat, oCnt
  );

  modport slave (
    input  iClr, iVld, iDat, iRdy,
    output oRdy, oVld, oDat, oCnt
  );

endinterface

// File: rtl/clr_en_dff_stage.sv
// One pipeline stage: a valid bit plus data word with synchronous active-low reset,
// synchronous clear and load enable. Data only loads alongside a valid word.
module clr_en_dff_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t r_stage;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_stage.vld <= 1'b0;
      r_stage.dat <= INI_DATA;
    end else if (i_en) begin
      r_stage.vld <= i_vld;
      // A bubble moving in leaves the old word in place so oDat stays stable.
      if (i_vld) begin
        r_stage.dat <= i_dat;
      end
    end
  end

  assign o_vld = r_stage.vld;
  assign o_dat = r_stage.dat;

endmodule

// File: rtl/clr_en_dff_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready flow control, bubble
// collapsing, whole-pipe synchronous flush and an occupancy count.
module clr_en_dff_pipe
  import clr_en_dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = DefWidth,
  parameter int unsigned      DEPTH    = DefDepth,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input logic              clk,
  input logic              rst,
  clr_en_dff_pipe_if.slave bus
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $fatal(1, "clr_en_dff_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH:0]   w_en;
  logic [DEPTH-1:0] w_vld;
  logic [WIDTH-1:0] w_dat [DEPTH];
  logic [CntW-1:0]  w_cnt;

  // A stage may load when it is empty or when the stage after it is moving.
  always_comb begin
    w_en        = '0;
    w_en[DEPTH] = bus.iRdy;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      w_en[k] = !w_vld[k] || w_en[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_in_vld;
    logic [WIDTH-1:0] w_in_dat;

    if (k == 0) begin : g_head
      assign w_in_vld = bus.iVld;
      assign w_in_dat = bus.iDat;
    end else begin : g_body
      assign w_in_vld = w_vld[k-1];
      assign w_in_dat = w_dat[k-1];
    end

    clr_en_dff_stage #(
      .WIDTH    (WIDTH),
      .INI_DATA (INI_DATA)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_clr (bus.iClr),
      .i_en  (w_en[k]),
      .i_vld (w_in_vld),
      .i_dat (w_in_dat),
      .o_vld (w_vld[k]),
      .o_dat (w_dat[k])
    );
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_cnt = w_cnt + CntW'(w_vld[k]);
    end
  end

  // Never advertise ready while the word would be dropped by reset or flush.
  assign bus.oRdy = w_en[0] && rst && !bus.iClr;
  assign bus.oVld = w_vld[DEPTH-1];
  assign bus.oDat = w_dat[DEPTH-1];
  assign bus.oCnt = w_cnt;

endmodule

// File: tb/tb_clr_en_dff_pipe.sv
// Self-checking bench for clr_en_dff_pipe (WIDTH=32, DEPTH=3, INI_DATA=1): directed
// table, multi-cycle corner sequences and random traffic against a slot/queue model.
module tb_clr_en_dff_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned D   = 3;
  localparam logic [31:0] INI = 32'h1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  clr_en_dff_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  clr_en_dff_pipe #(
    .WIDTH    (W),
    .DEPTH    (D),
    .INI_DATA (INI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: occupied slots and their held words, plus an in-order scoreboard.
  logic        m_v [D];
  logic [31:0] m_d [D];
  logic [31:0] q [$];

  logic        cur_r, cur_c, cur_v, cur_rd, cur_acc, cur_out;
  logic [31:0] cur_d;

  typedef struct {
    logic        r;
    logic        c;
    logic        v;
    logic [31:0] d;
    logic        rd;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    int          e_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int k = 0; k < int'(D); k++) n += int'(m_v[k]);
    return n;
  endfunction

  task automatic drive(input logic r, input logic c, input logic v, input logic [31:0] d,
                       input logic rd);
    logic e_rdy;
    rst      = r;
    bus.iClr = c;
    bus.iVld = v;
    bus.iDat = d;
    bus.iRdy = rd;
    #1;
    // Pipe can take a word when it has any empty slot or the head word is leaving.
    e_rdy = r && !c && ((model_cnt() < int'(D)) || rd);
    chk("oRdy", 32'(bus.oRdy), 32'(e_rdy));
    chk("oVld", 32'(bus.oVld), 32'(m_v[D-1]));
    chk("oDat", bus.oDat, m_d[D-1]);
    chk("oCnt", 32'(bus.oCnt), 32'(model_cnt()));
    cur_out = bus.oVld && rd;
    if (cur_out) begin
      chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) chk("sb_order", bus.oDat, q.pop_front());
    end
    cur_r = r; cur_c = c; cur_v = v; cur_d = d; cur_rd = rd;
    cur_acc = v && e_rdy;
  endtask

  task automatic model_clear();
    for (int k = 0; k < int'(D); k++) begin
      m_v[k] = 1'b0;
      m_d[k] = INI;
    end
    q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur_r || cur_c) begin
      model_clear();
    end else begin
      if (m_v[D-1] && cur_rd) m_v[D-1] = 1'b0;
      // Each word slides forward into any slot that is free after downstream moved.
      for (int k = int'(D) - 2; k >= 0; k--) begin
        if (m_v[k] && !m_v[k+1]) begin
          m_v[k+1] = 1'b1;
          m_d[k+1] = m_d[k];
          m_v[k]   = 1'b0;
        end
      end
      if (cur_acc) begin
        m_v[0] = 1'b1;
        m_d[0] = cur_d;
        q.push_back(cur_d);
      end
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w [5];
    int          idx;
    int          delivered;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 32'h1,  0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 32'h1,  0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h1,  0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h1,  0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 32'h1,  1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0, 32'h1,  2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA0, 3};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'hA4, 1'b1, 1'b1, 1'b1, 32'hA1, 3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA4, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hA4, 0};

    // Registers are unknown until the first reset edge; apply it unchecked.
    model_clear();
    rst = 1'b0; bus.iClr = 1'b0; bus.iVld = 1'b1; bus.iDat = 32'hA0; bus.iRdy = 1'b1;
    cur_r = 1'b0; cur_c = 1'b0; cur_acc = 1'b0; cur_rd = 1'b1; cur_d = 32'hA0; cur_v = 1'b1;
    tick();

    // Reset hold and streaming.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d_rdy", i), 32'(bus.oRdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_vld", i), 32'(bus.oVld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_dat", i), bus.oDat, tbl[i].e_dat);
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.oCnt), 32'(tbl[i].e_cnt));
      tick();
    end

    // Backpressure: only DEPTH words fit, then release and drain with no loss.
    for (int i = 0; i < 5; i++) w[i] = 32'hB0 + 32'(i);
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, w[idx], 1'b0);
      if (cur_acc) idx++;
      tick();
    end
    chk("bp_accepted", 32'(idx), 32'd3);
    drive(1'b1, 1'b0, 1'b1, w[idx], 1'b0);
    chk("bp_full_rdy", 32'(bus.oRdy), 32'd0);
    chk("bp_full_cnt", 32'(bus.oCnt), 32'd3);
    chk("bp_full_dat", bus.oDat, 32'hB0);
    drive(1'b1, 1'b0, 1'b1, w[idx], 1'b1);
    chk("bp_release_rdy", 32'(bus.oRdy), 32'd1);
    delivered = cur_out ? 1 : 0;
    if (cur_acc) idx++;
    tick();
    for (int i = 0; i < 20 && delivered < 5; i++) begin
      drive(1'b1, 1'b0, idx < 5, (idx < 5) ? w[idx] : 32'h0, 1'b1);
      if (cur_out) delivered++;
      if (cur_acc) idx++;
      tick();
    end
    chk("bp_delivered", 32'(delivered), 32'd5);
    chk("bp_all_taken", 32'(idx), 32'd5);

    // Bubble collapse: a lone word slides to the last stage, the next stops behind it.
    drive(1'b1, 1'b0, 1'b1, 32'h55, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);  tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);  tick();
    drive(1'b1, 1'b0, 1'b1, 32'h66, 1'b0);
    chk("bub_vld", 32'(bus.oVld), 32'd1);
    chk("bub_cnt1", 32'(bus.oCnt), 32'd1);
    chk("bub_dat", bus.oDat, 32'h55);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);  tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bub_cnt2", 32'(bus.oCnt), 32'd2);
    chk("bub_hold", bus.oDat, 32'h55);
    tick();

    // Flush mid-flight with a word on the input.
    drive(1'b1, 1'b1, 1'b1, 32'hBEEF, 1'b0);
    chk("flush_rdy", 32'(bus.oRdy), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush_cnt", 32'(bus.oCnt), 32'd0);
    chk("flush_vld", 32'(bus.oVld), 32'd0);
    chk("flush_dat", bus.oDat, 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("flush_no_beef", 32'(bus.oVld && bus.oDat == 32'hBEEF), 32'd0);
      tick();
    end

    // Reset pulse while full under backpressure, then fresh traffic.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("rstbp_full", 32'(bus.oCnt), 32'd3);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rstbp_cnt", 32'(bus.oCnt), 32'd0);
    chk("rstbp_dat", bus.oDat, 32'h1);
    tick();
    idx = 0;
    delivered = 0;
    for (int i = 0; i < 20 && delivered < 4; i++) begin
      drive(1'b1, 1'b0, idx < 4, 32'hD0 + 32'(idx), 1'b1);
      if (cur_out) delivered++;
      if (cur_acc) idx++;
      tick();
    end
    chk("rstbp_delivered", 32'(delivered), 32'd4);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
